seg7_bcd: RTL and testbench
===========================

# seg7_bcd

Bus-slave binary-to-BCD converter sitting directly upstream of the 7-segment driver. Software writes a binary count (0..9999). The block runs a sequential double-dabble conversion and pushes the packed BCD digits to the driver's digit register over a master bus port. Decimal display then costs software one write instead of a divide loop.

## Interface
- `DIGITS`, 4: BCD digits produced; fixed at 4 in this revision.
- `BIN_BITS`, 14: binary operand width used for conversion (covers 0..16383).
- `clk` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `strobe` in 1: slave access request, sampled each cycle.
- `rw` in 1: 1 = write, 0 = read.
- `addr` in 32: register select; only `addr[1:0]` is decoded.
- `d_in` in 32: write data.
- `d_out` out 32: registered read data.
- `ack` out 1: registered copy of `strobe`.
- `m_strobe` out 1: master write request to the 7-segment driver.
- `m_rw` out 1: always 1 while `m_strobe` is high.
- `m_addr` out 32: always 0, the driver's digit register.
- `m_d_out` out 32: `{16'b0, bcd}`.
- `m_ack` in 1: driver acknowledge.

## Operation
- Registers:
  - 0 VALUE: write starts a conversion; read returns the last accepted value, `{18'b0, value[13:0]}`.
  - 1 STATUS: read-only; bit0 busy, bit1 ovf, bit2 pending.
  - 2 BCD: read-only; `{16'b0, bcd}`.
  - 3: reads 0; writes ignored.
- Write to VALUE:
  - `d_in[31:0] > 9999` sets ovf=1. `bcd` is set to 16'hEEEE without running the FSM, then the block goes to PUSH.
  - Otherwise ovf=0, `d_in[13:0]` is loaded and the block goes to CONV.
- FSM states: IDLE, CONV, PUSH.
  - IDLE -> CONV on a valid write.
  - CONV runs exactly BIN_BITS iterations using a 4-bit iteration counter.
  - Each CONV cycle adds 3 to every BCD nibble that is ≥5, then shifts `{bcd, bin}` left by 1.
  - CONV -> PUSH after the 14th iteration.
  - PUSH -> IDLE in the cycle `m_ack` is sampled high.
- Writes while busy (CONV or PUSH): the value goes to a single pending slot, overwriting any earlier pending value, and sets pending=1. The current operation is not aborted. On return to IDLE a pending value starts immediately, with no IDLE cycle, and pending clears.
- Reads are always serviced regardless of state. BCD reads return the last completed result, never partial shift state.
- busy = (state != IDLE).

## Timing
- Reset values: `d_out` 0, `ack` 0, `m_strobe` 0, `m_rw` 1, `m_addr` 0, `m_d_out` 0. Also bcd 0, value 0, STATUS 0, state IDLE.
- `ack` asserts the cycle after `strobe`. `d_out` is valid in the same cycle as `ack`.
- Valid write sampled at edge T:
  - CONV covers edges T+1..T+14.
  - `bcd` is updated at T+14.
  - `m_strobe` is high from after T+14 until the edge where `m_ack`=1 is sampled, and deasserts after that edge.
- The 7-segment driver acks one cycle after strobe, so `m_strobe` stays high 2 cycles. Repeated identical writes to the driver are harmless.
- Overflow write at T: `bcd` = EEEE at T+1, `m_strobe` high after T+1.
- `m_d_out` is stable for the whole time `m_strobe` is high.
- `reset_n` low mid-CONV or mid-PUSH returns every output and register to its reset value immediately. The pending value is discarded.

## Configuration
- `SEG7_BCD_AUTOPUSH_EN`:
  - Defined: behaviour as above.
  - Undefined: PUSH is skipped (CONV -> IDLE), `m_strobe` is tied 0, and `m_ack` is ignored. Software reads BCD and writes the driver itself. Latency to "not busy" is T+15.

## Structure
- Shared package `seg7_pkg` holds:
  - state enum (IDLE/CONV/PUSH);
  - register offsets (REG_VALUE=0, REG_STATUS=1, REG_BCD=2);
  - STATUS bit indices;
  - `SEG7_DIGITS=4`;
  - `OVF_PATTERN=16'hEEEE`;
  - `BCD_MAX=9999`.
- One combinational sub-module, `bcd_adj3`, performs the per-nibble ≥5 → +3 adjust over DIGITS nibbles. The FSM, slave decode and master port live in the top.

## Test plan
- Write VALUE=1234 with `m_ack` = `m_strobe` delayed one cycle → BCD reads 0x1234 after T+14. `m_strobe` is high 2 cycles with `m_d_out`=0x1234 and `m_addr`=0.
- Write 10000 → STATUS=0x3 at T+1 (ovf, busy). `m_d_out`=0xEEEE. STATUS settles to 0x2.
- Write 9999 and 0 back-to-back → final BCD=0x0000. Two pushes occur, 0x9999 then 0x0000. Pending=1 is observed between them.
- Hold `m_ack` low for 5 cycles during PUSH → `m_strobe` stays high with stable data. busy stays 1 until the ack edge.
- Drop `reset_n` at T+7 of a 4321 conversion → all outputs 0 (`m_rw` 1), BCD=0, STATUS=0. A subsequent write of 42 yields 0x0042.
- With `SEG7_BCD_AUTOPUSH_EN` undefined, write 57 → `m_strobe` never asserts. BCD=0x0057 and busy=0 at T+15.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seg7_bcd binary-to-BCD converter.
package seg7_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      PUSH = 2'd2
   } state_t;

   localparam logic [1:0] REG_VALUE  = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_BCD    = 2'd2;

   localparam int ST_BUSY = 0;
   localparam int ST_OVF  = 1;
   localparam int ST_PEND = 2;

   localparam int          SEG7_DIGITS = 4;
   localparam logic [15:0] OVF_PATTERN = 16'hEEEE;
   localparam logic [31:0] BCD_MAX     = 32'd9999;

endpackage

// File: rtl/seg7_bcd_if.sv
// Bus bundle for seg7_bcd: CPU slave access plus the master write port to the 7-segment driver.
interface seg7_bcd_if;
   logic        strobe;
   logic        rw;
   logic [31:0] addr;
   logic [31:0] d_in;
   logic [31:0] d_out;
   logic        ack;
   logic        m_strobe;
   logic        m_rw;
   logic [31:0] m_addr;
   logic [31:0] m_d_out;
   logic        m_ack;

   modport slave (
      input  strobe, rw, addr, d_in, m_ack,
      output d_out, ack, m_strobe, m_rw, m_addr, m_d_out
   );

   modport master (
      output strobe, rw, addr, d_in, m_ack,
      input  d_out, ack, m_strobe, m_rw, m_addr, m_d_out
   );
endinterface

// File: rtl/bcd_adj3.sv
// Double-dabble adjust step: every BCD nibble that is 5 or more gets 3 added.
module bcd_adj3
   import seg7_pkg::*;
#(
   parameter int DIGITS = SEG7_DIGITS
) (
   input  logic [4*DIGITS-1:0] bcd_in,
   output logic [4*DIGITS-1:0] bcd_out
);

   for (genvar i = 0; i < DIGITS; i++) begin : g_nib
      assign bcd_out[4*i +: 4] = (bcd_in[4*i +: 4] >= 4'd5) ? bcd_in[4*i +: 4] + 4'd3
                                                           : bcd_in[4*i +: 4];
   end

endmodule

// File: rtl/seg7_bcd.sv
// Bus-slave binary-to-BCD converter; define SEG7_BCD_AUTOPUSH_EN to push each result
// to the 7-segment driver's digit register over the master port.
module seg7_bcd
   import seg7_pkg::*;
#(
   parameter int DIGITS   = SEG7_DIGITS,
   parameter int BIN_BITS = 14
) (
   input  logic      clk,
   input  logic      reset_n,
   seg7_bcd_if.slave bus,
   output state_t    dbg_state
);

   localparam int BW = 4 * DIGITS;

   // Handshake: strobe is a one-cycle request sampled each edge, ack is its registered
   // copy and d_out is valid alongside ack; on the master side m_strobe holds with
   // stable m_d_out until the edge at which m_ack is sampled high.
   state_t                state;
   logic [BW-1:0]         work, bcd, adj, work_next;
   logic [BIN_BITS-1:0]   bin_sr, value, pend_bin, start_bin;
   logic [3:0]            cnt;
   logic                  ovf, pend, pend_ovf, start_ovf;
   logic [31:0]           d_out_r, m_d_out_r, status;
   logic                  ack_r;
   logic                  wr_value, wr_ovf, last_iter, conv_done, finishing;
   logic                  start_new, start_pend;

   bcd_adj3 #(.DIGITS(DIGITS)) u_adj (
      .bcd_in  (work),
      .bcd_out (adj)
   );

   assign wr_value  = bus.strobe && bus.rw && (bus.addr[1:0] == REG_VALUE);
   assign wr_ovf    = bus.d_in > BCD_MAX;
   assign work_next = {adj[BW-2:0], bin_sr[BIN_BITS-1]};
   assign last_iter = (cnt == 4'(BIN_BITS - 1));
   assign conv_done = (state == CONV) && (ovf || last_iter);

`ifdef SEG7_BCD_AUTOPUSH_EN
   logic m_strobe_r;
   assign finishing    = (state == PUSH) && bus.m_ack;
   assign bus.m_strobe = m_strobe_r;
`else
   assign finishing    = conv_done;
   assign bus.m_strobe = 1'b0;
`endif

   // A write landing on the finishing edge is newer than any pending value, so it wins.
   assign start_new  = wr_value && ((state == IDLE) || finishing);
   assign start_pend = !wr_value && pend && finishing;
   assign start_ovf  = start_new ? wr_ovf : pend_ovf;
   assign start_bin  = start_new ? bus.d_in[BIN_BITS-1:0] : pend_bin;

   always_comb begin
      status          = '0;
      status[ST_BUSY] = (state != IDLE);
      status[ST_OVF]  = ovf;
      status[ST_PEND] = pend;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         work      <= '0;
         bcd       <= '0;
         bin_sr    <= '0;
         value     <= '0;
         pend_bin  <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         pend      <= 1'b0;
         pend_ovf  <= 1'b0;
         d_out_r   <= '0;
         m_d_out_r <= '0;
         ack_r     <= 1'b0;
`ifdef SEG7_BCD_AUTOPUSH_EN
         m_strobe_r <= 1'b0;
`endif
      end else begin
         ack_r <= bus.strobe;
         if (bus.strobe && !bus.rw) begin
            case (bus.addr[1:0])
               REG_VALUE:  d_out_r <= 32'(value);
               REG_STATUS: d_out_r <= status;
               REG_BCD:    d_out_r <= 32'(bcd);
               default:    d_out_r <= '0;
            endcase
         end

         if (wr_value) value <= bus.d_in[BIN_BITS-1:0];
         if (wr_value && (state != IDLE) && !finishing) begin
            pend     <= 1'b1;
            pend_bin <= bus.d_in[BIN_BITS-1:0];
            pend_ovf <= wr_ovf;
         end

         case (state)
            IDLE: ;
            CONV: begin
               if (ovf) begin
                  bcd <= BW'(OVF_PATTERN);
               end else begin
                  work   <= work_next;
                  bin_sr <= bin_sr << 1;
                  cnt    <= cnt + 4'd1;
                  if (last_iter) bcd <= work_next;
               end
               if (conv_done) begin
                  m_d_out_r <= ovf ? 32'(OVF_PATTERN) : 32'(work_next);
`ifdef SEG7_BCD_AUTOPUSH_EN
                  state      <= PUSH;
                  m_strobe_r <= 1'b1;
`else
                  state      <= IDLE;
`endif
               end
            end
`ifdef SEG7_BCD_AUTOPUSH_EN
            PUSH: begin
               if (bus.m_ack) begin
                  m_strobe_r <= 1'b0;
                  state      <= IDLE;
               end
            end
`endif
            default: state <= IDLE;
         endcase

         // Overrides the IDLE transition above so a queued value starts with no gap.
         if (start_new || start_pend) begin
            state  <= CONV;
            ovf    <= start_ovf;
            bin_sr <= start_bin;
            work   <= '0;
            cnt    <= '0;
            pend   <= 1'b0;
         end
      end
   end

   assign bus.d_out   = d_out_r;
   assign bus.ack     = ack_r;
   assign bus.m_rw    = 1'b1;
   assign bus.m_addr  = '0;
   assign bus.m_d_out = m_d_out_r;
   assign dbg_state   = state;

endmodule

// File: tb/tb_seg7_bcd.sv
// Self-checking bench for seg7_bcd: directed scenarios plus random bus traffic against a
// cycle-timed behavioural model; honours SEG7_BCD_AUTOPUSH_EN like the design.
module tb_seg7_bcd;
  import seg7_pkg::*;

  logic   clk;
  logic   reset_n;
  state_t dbg_state;
  int     n_tests;
  int     n_fail;
  bit     ack_block;
  bit     ack_prev;

  seg7_bcd_if bus ();

  seg7_bcd dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int unsigned  conv_left;
  bit           pushing;
  bit           mdl_pend;
  bit           mdl_ovf;
  logic [31:0]  mdl_pend_val;
  logic [13:0]  mdl_value;
  logic [15:0]  mdl_bcd;
  logic [15:0]  mdl_result;
  logic [15:0]  mdl_mdout;
  logic [31:0]  mdl_dout;
  bit           mdl_ack;
  logic [15:0]  exp_q[$];
  logic [15:0]  push_log[$];

  function automatic logic [15:0] to_bcd(input logic [31:0] v);
    int unsigned n;
    n = v;
    if (n > 9999) return 16'hEEEE;
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic bit mdl_busy();
    return (conv_left != 0) || pushing;
  endfunction

  task mdl_start(input logic [31:0] v);
    mdl_ovf    = (v > 32'd9999);
    mdl_result = to_bcd(v);
    conv_left  = mdl_ovf ? 1 : 14;
  endtask

  task mdl_reset();
    conv_left = 0; pushing = 0; mdl_pend = 0; mdl_ovf = 0;
    mdl_pend_val = '0; mdl_value = '0; mdl_bcd = '0; mdl_result = '0;
    mdl_mdout = '0; mdl_dout = '0; mdl_ack = 0;
    exp_q.delete();
  endtask

  always @(posedge clk or negedge reset_n) begin
    bit busy_b, fin, wr;
    if (!reset_n) begin
      mdl_reset();
    end else begin
      busy_b  = mdl_busy();
      mdl_ack = bus.strobe;
      if (bus.strobe && !bus.rw) begin
        case (bus.addr[1:0])
          2'd0:    mdl_dout = {18'b0, mdl_value};
          2'd1:    mdl_dout = {29'b0, mdl_pend, mdl_ovf, busy_b};
          2'd2:    mdl_dout = {16'b0, mdl_bcd};
          default: mdl_dout = '0;
        endcase
      end
      fin = 0;
      if (conv_left != 0) begin
        conv_left--;
        if (conv_left == 0) begin
          mdl_bcd   = mdl_result;
          mdl_mdout = mdl_result;
`ifdef SEG7_BCD_AUTOPUSH_EN
          pushing = 1;
          exp_q.push_back(mdl_result);
`else
          fin = 1;
`endif
        end
      end else if (pushing && bus.m_ack) begin
        pushing = 0;
        fin     = 1;
      end
      wr = bus.strobe && bus.rw && (bus.addr[1:0] == 2'd0);
      if (wr) mdl_value = bus.d_in[13:0];
      if (!busy_b || fin) begin
        if (wr) begin
          mdl_start(bus.d_in);
          mdl_pend = 0;
        end else if (fin && mdl_pend) begin
          mdl_start(mdl_pend_val);
          mdl_pend = 0;
        end
      end else if (wr) begin
        mdl_pend     = 1;
        mdl_pend_val = bus.d_in;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cyc_ack", {31'b0, bus.ack}, {31'b0, mdl_ack});
    check("cyc_d_out", bus.d_out, mdl_dout);
    check("cyc_m_strobe", {31'b0, bus.m_strobe}, {31'b0, pushing});
    check("cyc_m_rw", {31'b0, bus.m_rw}, 32'd1);
    check("cyc_m_addr", bus.m_addr, 32'd0);
    check("cyc_m_d_out", bus.m_d_out, {16'b0, mdl_mdout});
    check("cyc_busy", {31'b0, dbg_state != IDLE}, {31'b0, mdl_busy()});
  end

  // Driver acknowledges one cycle after it sees m_strobe, unless stalled.
  always @(negedge clk) begin
    bus.m_ack = ack_prev && !ack_block;
    ack_prev  = bus.m_strobe;
  end

  always @(posedge clk) begin
    if (reset_n && bus.m_strobe && bus.m_ack) begin
      push_log.push_back(bus.m_d_out[15:0]);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL push_unexpected: got 0x%04h, expected no push", bus.m_d_out[15:0]);
      end else begin
        check("push_data_q", bus.m_d_out, {16'b0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.strobe = 1'b1; bus.rw = 1'b1; bus.addr = a; bus.d_in = d;
    @(negedge clk);
    bus.strobe = 1'b0; bus.rw = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.strobe = 1'b1; bus.rw = 1'b0; bus.addr = a;
    @(negedge clk);
    bus.strobe = 1'b0;
    d = bus.d_out;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (dbg_state != IDLE && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", {31'b0, dbg_state == IDLE}, 32'd1);
  endtask

  task automatic measure_push(input logic [15:0] exp_data, output int first, output int len);
    first = -1;
    len   = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.m_strobe) begin
        if (first < 0) first = k;
        len++;
        check("push_data_lit", bus.m_d_out, {16'b0, exp_data});
      end else if (first >= 0) begin
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd, v, r;
    logic [1:0]  a;
    int          first, len, base, op;

    n_tests = 0; n_fail = 0; ack_block = 0;
    bus.strobe = 0; bus.rw = 0; bus.addr = '0; bus.d_in = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_d_out", bus.d_out, 32'd0);
    check("rst_ack", {31'b0, bus.ack}, 32'd0);
    check("rst_m_strobe", {31'b0, bus.m_strobe}, 32'd0);
    check("rst_m_rw", {31'b0, bus.m_rw}, 32'd1);
    check("rst_m_d_out", bus.m_d_out, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(32'd1, rd); check("rst_status", rd, 32'h0);
    bus_read(32'd2, rd); check("rst_bcd", rd, 32'h0);

`ifdef SEG7_BCD_AUTOPUSH_EN
    bus_write(32'd0, 32'd1234);
    measure_push(16'h1234, first, len);
    check("push_start_cycle", first, 32'd14);
    check("push_len", len, 32'd2);
    wait_idle(50);
    bus_read(32'd2, rd); check("bcd_1234", rd, 32'h1234);
`else
    bus_write(32'd0, 32'd57);
    repeat (13) @(negedge clk);
    bus_read(32'd1, rd); check("status_t14", rd, 32'h1);
    bus_read(32'd1, rd); check("status_t15", rd, 32'h0);
    bus_read(32'd2, rd); check("bcd_57", rd, 32'h0057);
`endif

    base = push_log.size();
    bus_write(32'd0, 32'd10000);
    bus_read(32'd1, rd); check("ovf_status_busy", rd, 32'h3);
    wait_idle(50);
    bus_read(32'd1, rd); check("ovf_status_idle", rd, 32'h2);
    bus_read(32'd2, rd); check("ovf_bcd", rd, 32'hEEEE);
    bus_read(32'd0, rd); check("ovf_value", rd, 32'd10000);
`ifdef SEG7_BCD_AUTOPUSH_EN
    check("ovf_push", {16'b0, push_log[base]}, 32'hEEEE);
`endif

    base = push_log.size();
    bus_write(32'd0, 32'd9999);
    bus_write(32'd0, 32'd0);
    bus_read(32'd1, rd); check("pend_status", rd, 32'h5);
    wait_idle(100);
    bus_read(32'd2, rd); check("b2b_bcd", rd, 32'h0);
`ifdef SEG7_BCD_AUTOPUSH_EN
    check("b2b_push_count", push_log.size() - base, 32'd2);
    check("b2b_push0", {16'b0, push_log[base]}, 32'h9999);
    check("b2b_push1", {16'b0, push_log[base+1]}, 32'h0000);

    ack_block = 1;
    bus_write(32'd0, 32'd777);
    first = 0;
    while (!bus.m_strobe && first < 40) begin @(negedge clk); first++; end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_m_strobe", {31'b0, bus.m_strobe}, 32'd1);
      check("stall_data", bus.m_d_out, 32'h0777);
      check("stall_busy", {31'b0, dbg_state != IDLE}, 32'd1);
    end
    ack_block = 0;
    wait_idle(20);
`endif

    bus_write(32'd0, 32'd4321);
    bus_read(32'd0, rd); check("value_4321", rd, 32'd4321);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_d_out", bus.d_out, 32'd0);
    check("mid_rst_ack", {31'b0, bus.ack}, 32'd0);
    check("mid_rst_m_strobe", {31'b0, bus.m_strobe}, 32'd0);
    check("mid_rst_m_rw", {31'b0, bus.m_rw}, 32'd1);
    check("mid_rst_m_d_out", bus.m_d_out, 32'd0);
    check("mid_rst_idle", {31'b0, dbg_state == IDLE}, 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(32'd2, rd); check("post_rst_bcd", rd, 32'h0);
    bus_read(32'd1, rd); check("post_rst_status", rd, 32'h0);
    bus_write(32'd0, 32'd42);
    wait_idle(50);
    bus_read(32'd2, rd); check("bcd_42", rd, 32'h0042);

    for (int i = 0; i < 250; i++) begin
      op = $urandom_range(0, 9);
      r  = $urandom();
      if (op <= 4) begin
        case ($urandom_range(0, 7))
          0:       v = 32'd9999;
          1:       v = 32'd10000;
          2:       v = $urandom();
          3:       v = 32'd0;
          default: v = $urandom_range(0, 9999);
        endcase
        a = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        bus_write({r[31:2], a}, v);
      end else if (op <= 7) begin
        a = 2'($urandom_range(0, 3));
        bus_read({r[31:2], a}, rd);
      end else if (op == 8) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end else begin
        ack_block = ($urandom_range(0, 2) == 0);
      end
    end
    ack_block = 0;
    wait_idle(400);
    repeat (3) @(negedge clk);
`ifdef SEG7_BCD_AUTOPUSH_EN
    check("push_q_drained", exp_q.size(), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
